// File: rtl/shift_pkg.sv
// Shared encodings for the serial word collector: FSM states and bit-order values.
package shift_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COLLECT = 2'd1,
        ST_PARITY  = 2'd2
    } state_t;

    localparam logic ORDER_MSB_FIRST = 1'b0;
    localparam logic ORDER_LSB_FIRST = 1'b1;

endpackage

// File: rtl/serial_word_collector_out_buffer.sv
// One-entry valid/ready holding register; a completion that finds the entry
// full and not being popped is dropped and recorded in the sticky overflow flag.
module out_buffer #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         clear,
    input  logic         load,
    input  logic [W-1:0] load_data,
    input  logic         load_par,
    input  logic         word_ready,
    output logic [W-1:0] word_out,
    output logic         word_valid,
    output logic         parity_err,
    output logic         overflow
);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            word_out   <= '0;
            word_valid <= 1'b0;
            parity_err <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (load) begin
                // A pop on the same edge frees the slot, so the new word wins.
                if (!word_valid || word_ready) begin
                    word_out   <= load_data;
                    parity_err <= load_par;
                    word_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end else if (word_valid && word_ready) begin
                word_valid <= 1'b0;
            end
            if (clear)
                overflow <= 1'b0;
        end
    end

endmodule

// File: rtl/serial_word_collector.sv
// Serial-to-parallel collector: assembles W-bit words from a bit stream in either order.
// Define SERIAL_COLLECTOR_PARITY_EN to append an even-parity bit to each frame.
module serial_word_collector
    import shift_pkg::*;
#(
    parameter int W = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   clear,
    input  logic                   bit_in,
    input  logic                   bit_valid,
    input  logic                   lsb_first,
    output logic [W-1:0]           word_out,
    output logic                   word_valid,
    input  logic                   word_ready,
    output logic                   parity_err,
    output logic                   overflow,
    output logic                   busy,
    output logic [$clog2(W+1)-1:0] bit_count
);

    localparam int CW = $clog2(W+1);

    state_t         state;
    logic [W-1:0]   acc;
    logic           order;
    logic           eff_order;
    logic [W-1:0]   shifted;
    logic           take;
    logic           complete;
    logic [W-1:0]   complete_word;
    logic           complete_par;

    // Order is taken live on the first bit of a frame, then held for the rest.
    always_comb begin
        eff_order = (state == ST_IDLE) ? lsb_first : order;
        shifted   = (eff_order == ORDER_LSB_FIRST) ? {bit_in, acc[W-1:1]}
                                                   : {acc[W-2:0], bit_in};
    end

    assign take = bit_valid && !clear;

`ifdef SERIAL_COLLECTOR_PARITY_EN
    assign complete      = take && (state == ST_PARITY);
    assign complete_word = acc;
    assign complete_par  = ^{acc, bit_in};
`else
    assign complete      = take && (state == ST_COLLECT) && (bit_count == CW'(W-1));
    assign complete_word = shifted;
    assign complete_par  = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ST_IDLE;
            acc       <= '0;
            order     <= ORDER_LSB_FIRST;
            bit_count <= '0;
        end else if (clear) begin
            state     <= ST_IDLE;
            bit_count <= '0;
        end else if (bit_valid) begin
            case (state)
                ST_IDLE: begin
                    order     <= lsb_first;
                    acc       <= shifted;
                    bit_count <= CW'(1);
                    state     <= ST_COLLECT;
                end
                ST_COLLECT: begin
                    acc <= shifted;
                    if (bit_count == CW'(W-1)) begin
`ifdef SERIAL_COLLECTOR_PARITY_EN
                        bit_count <= CW'(W);
                        state     <= ST_PARITY;
`else
                        bit_count <= '0;
                        state     <= ST_IDLE;
`endif
                    end else begin
                        bit_count <= bit_count + CW'(1);
                    end
                end
                default: begin
                    bit_count <= '0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = (state != ST_IDLE);

    out_buffer #(.W(W)) u_out_buffer (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .load       (complete),
        .load_data  (complete_word),
        .load_par   (complete_par),
        .word_ready (word_ready),
        .word_out   (word_out),
        .word_valid (word_valid),
        .parity_err (parity_err),
        .overflow   (overflow)
    );

endmodule

// File: tb/tb_serial_word_collector.sv
// Self-checking bench for serial_word_collector; accepted words are checked
// against a scoreboard queue filled as frames are driven.
module tb_serial_word_collector;

    localparam int W  = 16;
    localparam int CW = $clog2(W+1);

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          clear = 1'b0;
    logic          bit_in = 1'b0;
    logic          bit_valid = 1'b0;
    logic          lsb_first = 1'b1;
    logic [W-1:0]  word_out;
    logic          word_valid;
    logic          word_ready = 1'b0;
    logic          parity_err;
    logic          overflow;
    logic          busy;
    logic [CW-1:0] bit_count;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [W-1:0]  exp_q[$];
    logic          pre_valid;

    serial_word_collector #(.W(W)) dut (
        .clk        (clk),
        .reset      (reset),
        .clear      (clear),
        .bit_in     (bit_in),
        .bit_valid  (bit_valid),
        .lsb_first  (lsb_first),
        .word_out   (word_out),
        .word_valid (word_valid),
        .word_ready (word_ready),
        .parity_err (parity_err),
        .overflow   (overflow),
        .busy       (busy),
        .bit_count  (bit_count)
    );

    always #5 clk = ~clk;

    // Every handshake that will occur at the next rising edge is scored here.
    always @(negedge clk) begin
        if (!reset && word_valid && word_ready) begin
            logic [W-1:0] e;
            n_checks++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("FAIL scoreboard_unexpected: got word %h, expected none", word_out);
            end else begin
                e = exp_q.pop_front();
                if (word_out !== e) begin
                    n_fail++;
                    $display("FAIL scoreboard_word: got %h, expected %h", word_out, e);
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [W-1:0] rev(input logic [W-1:0] d);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = d[W-1-i];
        return r;
    endfunction

    // lsb_first is flipped after the first bit to confirm it is latched per frame.
    task automatic send_frame(input logic [W-1:0] data, input bit send_lsb, input bit lsbf,
                              input bit pbit, input bit ready_last);
        lsb_first = lsbf;
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1;
            bit_in    = send_lsb ? data[i] : data[W-1-i];
`ifndef SERIAL_COLLECTOR_PARITY_EN
            if (i == W-1) begin
                pre_valid = word_valid;
                if (ready_last) word_ready = 1'b1;
            end
`endif
            tick();
            if (i == 0) lsb_first = !lsbf;
        end
`ifdef SERIAL_COLLECTOR_PARITY_EN
        bit_valid = 1'b1;
        bit_in    = pbit;
        pre_valid = word_valid;
        if (ready_last) word_ready = 1'b1;
        tick();
`endif
        bit_valid = 1'b0;
        if (ready_last) word_ready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        #2;
        n_checks++;
        if ({word_out, word_valid, parity_err, overflow, busy, bit_count} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got out=%h v=%b p=%b ovf=%b busy=%b cnt=%0d, expected all 0",
                     word_out, word_valid, parity_err, overflow, busy, bit_count);
        end
        tick();
        reset = 1'b0;
        tick();
    endtask

    task automatic test_lsb_first();
        word_ready = 1'b1;
        exp_q.push_back(16'hA5C3);
        send_frame(16'hA5C3, 1'b1, 1'b1, ^16'hA5C3, 1'b0);
        n_checks++;
        if (pre_valid !== 1'b0 || word_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL lsb_latency: valid before/after last bit %b/%b, expected 0/1", pre_valid, word_valid);
        end
        n_checks++;
        if (overflow !== 1'b0 || parity_err !== 1'b0 || busy !== 1'b0 || bit_count !== '0) begin
            n_fail++;
            $display("FAIL lsb_status: ovf=%b p=%b busy=%b cnt=%0d, expected 0 0 0 0",
                     overflow, parity_err, busy, bit_count);
        end
        tick();
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL lsb_pop: word_valid=%b, expected 0", word_valid);
        end
    endtask

    task automatic test_msb_first();
        word_ready = 1'b1;
        exp_q.push_back(rev(16'hA5C3));
        send_frame(16'hA5C3, 1'b1, 1'b0, ^16'hA5C3, 1'b0);
        tick();
        exp_q.push_back(16'h1E5B);
        send_frame(16'h1E5B, 1'b0, 1'b0, ^16'h1E5B, 1'b0);
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL msb_drain: %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_overflow();
        word_ready = 1'b0;
        send_frame(16'h1234, 1'b1, 1'b1, ^16'h1234, 1'b0);
        send_frame(16'hFFFF, 1'b1, 1'b1, ^16'hFFFF, 1'b0);
        n_checks++;
        if (word_out !== 16'h1234 || word_valid !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_hold: out=%h v=%b ovf=%b, expected 1234 1 1", word_out, word_valid, overflow);
        end
        exp_q.push_back(16'h1234);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        tick();
        n_checks++;
        if (word_valid !== 1'b0 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL ovf_sticky: v=%b ovf=%b, expected 0 1", word_valid, overflow);
        end
        clear = 1'b1;
        tick();
        clear = 1'b0;
        n_checks++;
        if (overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL ovf_clear: ovf=%b, expected 0", overflow);
        end
    endtask

    task automatic test_pop_same_edge();
        word_ready = 1'b0;
        exp_q.push_back(16'h5A5A);
        send_frame(16'h5A5A, 1'b1, 1'b1, ^16'h5A5A, 1'b0);
        send_frame(16'h0F0F, 1'b1, 1'b1, ^16'h0F0F, 1'b1);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 16'h0F0F || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_same_edge: v=%b out=%h ovf=%b, expected 1 0f0f 0", word_valid, word_out, overflow);
        end
        exp_q.push_back(16'h0F0F);
        word_ready = 1'b1;
        tick();
        n_checks++;
        if (word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL pop_drain: v=%b, expected 0", word_valid);
        end
    endtask

    task automatic test_back_to_back();
        word_ready = 1'b1;
        exp_q.push_back(16'h8001);
        exp_q.push_back(16'h7FFE);
        send_frame(16'h8001, 1'b1, 1'b1, ^16'h8001, 1'b0);
        send_frame(16'h7FFE, 1'b1, 1'b1, ^16'h7FFE, 1'b0);
        tick();
        n_checks++;
        if (exp_q.size() != 0 || overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL back_to_back: pending=%0d ovf=%b, expected 0 0", exp_q.size(), overflow);
        end
    endtask

    task automatic test_clear();
        word_ready = 1'b1;
        lsb_first  = 1'b1;
        for (int i = 0; i < 7; i++) begin
            bit_valid = 1'b1;
            bit_in    = 1'b1;
            tick();
        end
        clear = 1'b1;
        tick();
        clear     = 1'b0;
        bit_valid = 1'b0;
        n_checks++;
        if (bit_count !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL clear_abort: cnt=%0d busy=%b, expected 0 0", bit_count, busy);
        end
        exp_q.push_back(16'h00FF);
        send_frame(16'h00FF, 1'b1, 1'b1, ^16'h00FF, 1'b0);
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL clear_frame: %0d words pending, expected 0", exp_q.size());
        end
    endtask

    task automatic test_reset_mid_frame();
        word_ready = 1'b0;
        send_frame(16'h3333, 1'b1, 1'b1, ^16'h3333, 1'b0);
        send_frame(16'h4444, 1'b1, 1'b1, ^16'h4444, 1'b0);
        lsb_first = 1'b1;
        for (int i = 0; i < 9; i++) begin
            bit_valid = 1'b1;
            bit_in    = i[0];
            tick();
        end
        bit_valid = 1'b0;
        n_checks++;
        if (bit_count !== CW'(9) || busy !== 1'b1 || overflow !== 1'b1) begin
            n_fail++;
            $display("FAIL mid_frame_state: cnt=%0d busy=%b ovf=%b, expected 9 1 1", bit_count, busy, overflow);
        end
        #2 reset = 1'b1;
        #1;
        n_checks++;
        if ({word_out, word_valid, parity_err, overflow, busy, bit_count} !== '0) begin
            n_fail++;
            $display("FAIL async_reset: out=%h v=%b p=%b ovf=%b busy=%b cnt=%0d, expected all 0",
                     word_out, word_valid, parity_err, overflow, busy, bit_count);
        end
        tick();
        reset = 1'b0;
        word_ready = 1'b1;
        exp_q.push_back(16'hBEEF);
        send_frame(16'hBEEF, 1'b1, 1'b1, ^16'hBEEF, 1'b0);
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL post_reset_frame: %0d words pending, expected 0", exp_q.size());
        end
    endtask

`ifdef SERIAL_COLLECTOR_PARITY_EN
    task automatic test_parity();
        word_ready = 1'b0;
        lsb_first  = 1'b1;
        for (int i = 0; i < W; i++) begin
            bit_valid = 1'b1;
            bit_in    = (i == 0);
            tick();
        end
        bit_valid = 1'b0;
        n_checks++;
        if (bit_count !== CW'(W) || busy !== 1'b1 || word_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_wait: cnt=%0d busy=%b v=%b, expected %0d 1 0", bit_count, busy, word_valid, W);
        end
        bit_valid = 1'b1;
        bit_in    = 1'b1;
        tick();
        bit_valid = 1'b0;
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 16'h0001 || parity_err !== 1'b0) begin
            n_fail++;
            $display("FAIL parity_good: v=%b out=%h p=%b, expected 1 0001 0", word_valid, word_out, parity_err);
        end
        exp_q.push_back(16'h0001);
        word_ready = 1'b1;
        tick();
        word_ready = 1'b0;
        send_frame(16'h0001, 1'b1, 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (word_valid !== 1'b1 || word_out !== 16'h0001 || parity_err !== 1'b1) begin
            n_fail++;
            $display("FAIL parity_bad: v=%b out=%h p=%b, expected 1 0001 1", word_valid, word_out, parity_err);
        end
        exp_q.push_back(16'h0001);
        word_ready = 1'b1;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_lsb_first();
        test_msb_first();
        test_overflow();
        test_pop_same_edge();
        test_back_to_back();
        test_clear();
        test_reset_mid_frame();
`ifdef SERIAL_COLLECTOR_PARITY_EN
        test_parity();
`endif
        tick();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL final_drain: %0d words pending, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_word_collector.md
# serial_word_collector

Serial-to-parallel collector that sits directly downstream of the lab shift register. It samples the single-bit stream shifted out of that register, one bit per qualified clock, and assembles W-bit words in either bit order. Each completed word is presented on a one-entry valid/ready output buffer. Words that arrive while the buffer is still full are dropped and flagged as overflow.

## Interface
Parameters:
- W, 16, data word width in bits; legal range 2..32.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state.
- clear  input  1  synchronous; aborts the partial frame and clears the sticky overflow flag.
- bit_in  input  1  serial data bit.
- bit_valid  input  1  bit_in is sampled at this edge when high.
- lsb_first  input  1  bit order; 1 = first bit becomes word bit 0 (right-shift order), 0 = first bit becomes bit W-1. Latched on the first bit of each frame.
- word_out  output  W  completed word; stable while word_valid is high.
- word_valid  output  1  output buffer full.
- word_ready  input  1  consumer accepts the word when high together with word_valid.
- parity_err  output  1  parity result for word_out; qualified by word_valid.
- overflow  output  1  sticky; a completed word was dropped.
- busy  output  1  a frame is partially collected.
- bit_count  output  $clog2(W+1)  bits collected in the current frame.

## Operation
- Reset values: word_out=0, word_valid=0, parity_err=0, overflow=0, busy=0, bit_count=0, FSM=IDLE.
- FSM states: IDLE, COLLECT, PARITY (PARITY exists only with the macro defined).
  - IDLE: a bit_valid edge latches lsb_first, shifts in the bit, sets bit_count=1 and moves to COLLECT. Exception: W=1 is illegal, so no frame completes from IDLE.
  - COLLECT: each bit_valid edge shifts in one bit and increments bit_count.
  - On the edge that samples bit W: go to PARITY if enabled, otherwise the word completes and the FSM returns to IDLE.
  - PARITY: the next bit_valid edge samples the parity bit, the word completes, and the FSM returns to IDLE.
- Shift rules:
  - lsb_first=1: acc <= {bit_in, acc[W-1:1]}.
  - lsb_first=0: acc <= {acc[W-2:0], bit_in}.
- Word completion, when word_valid=0 or word_ready=1 at that edge: load word_out and parity_err, set word_valid=1.
- Word completion, when word_valid=1 and word_ready=0: drop the word, set overflow=1, and leave word_out unchanged.
- Pop: word_valid && word_ready at an edge with no completion clears word_valid.
- Pop and completion at the same edge: the new word loads, word_valid stays 1, and overflow is not set.
- The serial side has no backpressure; collection never stalls.
- bit_valid=0 holds all collection state, so gaps between bits of any length are allowed.
- clear:
  - Returns the FSM to IDLE, sets bit_count=0 and clears overflow.
  - Does not touch word_out or word_valid.
  - Has priority over a bit arriving at the same edge; that bit is discarded.
- busy = (state != IDLE).

## Timing
- Latency: word_valid rises at the same edge that samples the last bit (data bit W, or the parity bit when enabled), so it is visible in the following cycle.
- Back-to-back frames: bit 1 of the next frame may arrive in the cycle immediately after completion.
- Output handshake: the buffer sustains one word per cycle.
- Reset asserted mid-frame: state clears immediately and asynchronously; the partial word is lost and overflow is cleared.

## Configuration
- Macro: SERIAL_COLLECTOR_PARITY_EN.
- Defined:
  - Each frame is W data bits plus one even-parity bit.
  - parity_err = XOR of all data bits and the parity bit, registered with word_out.
  - The PARITY state exists, and bit_count reaches W before the parity bit.
- Undefined:
  - Frame is W bits; no PARITY state.
  - parity_err is constant 0.

## Structure
- Shared package shift_pkg holds:
  - the state encoding constants ST_IDLE, ST_COLLECT, ST_PARITY;
  - the bit-order constants ORDER_MSB_FIRST=0, ORDER_LSB_FIRST=1.
- Sub-module out_buffer: the one-entry valid/ready holding register with the overflow decision. The FSM and shift accumulator stay in the top module.

## Test plan
- W=16, no parity, lsb_first=1, word_ready=1, bits of 0xA5C3 sent LSB first on consecutive cycles -> word_out=0xA5C3 and word_valid high one cycle after bit 16; overflow=0.
- Same bits with lsb_first=0 -> word_out=0x C3A5 bit-reversed, i.e. 0xC3A5 reversed = 0xA5C3 reversed-order value 0xC3A5; must match bitwise reversal of the sent order.
- word_ready=0, two frames 0x1234 then 0xFFFF -> word_out stays 0x1234 and overflow=1. Then word_ready=1 for one cycle -> word_valid=0; overflow stays 1 until a clear pulse.
- Frame completes on the same edge as a pop of the previous word -> word_valid stays high, the new value is loaded, overflow=0.
- clear after 7 bits, then a full frame of 0x00FF -> word_out=0x00FF with no leftover bits.
- Reset after 9 bits -> all outputs 0 immediately.
- PARITY_EN: 0x0001 with parity bit 1 -> parity_err=0; with parity bit 0 -> parity_err=1.
